// File: rtl/adio_rx_pkg.sv
// Shared constants for the audio ADC I2S receiver: sample width and FSM state encodings.
package adio_rx_pkg;

    // Width of a captured audio word (matches the DAC-side voltage word).
    localparam int VoltW = 16;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StDelay = 2'd1;
    localparam state_t StShift = 2'd2;
    localparam state_t StWait  = 2'd3;

    localparam logic ChanL = 1'b0;
    localparam logic ChanR = 1'b1;

endpackage

// File: rtl/adio_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a registered previous value
// so a clean 0->1 transition can be flagged in the clk domain.
module adio_rx_sync_edge #(
    parameter int Stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign q_o    = sync_q[Stages-1];
    assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/adio_rx.sv
// I2S capture receiver: oversamples bclk/lrclk/data in the clk domain, deserialises
// MSB-first left/right words and presents stereo pairs on a valid/ready handshake.
module adio_rx
    import adio_rx_pkg::*;
#(
    parameter int SAMPLE_W    = VoltW,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adc_bclk,
    input  logic                adc_lrclk,
    input  logic                adc_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                overrun,
    output logic                frame_err
);

    localparam int CntW = $clog2(SAMPLE_W);

    // Reset asserts asynchronously but releases on a clk edge.
    logic [1:0] rst_sync_q;
    logic       arst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign arst = rst_sync_q[1];

    logic bclk_s;
    logic lrclk_s;
    logic data_s;
    logic tick;
    logic lrclk_rise;
    logic data_rise;
    logic unused_sync;

    adio_rx_sync_edge #(
        .Stages (SYNC_STAGES)
    ) u_sync_bclk (
        .clk    (clk),
        .rst    (arst),
        .d_i    (adc_bclk),
        .q_o    (bclk_s),
        .rise_o (tick)
    );

    adio_rx_sync_edge #(
        .Stages (SYNC_STAGES)
    ) u_sync_lrclk (
        .clk    (clk),
        .rst    (arst),
        .d_i    (adc_lrclk),
        .q_o    (lrclk_s),
        .rise_o (lrclk_rise)
    );

    adio_rx_sync_edge #(
        .Stages (SYNC_STAGES)
    ) u_sync_data (
        .clk    (clk),
        .rst    (arst),
        .d_i    (adc_data),
        .q_o    (data_s),
        .rise_o (data_rise)
    );

    assign unused_sync = bclk_s ^ lrclk_rise ^ data_rise;

    // Deserialiser state. state_q classifies the most recent tick's bit within its slot.
    state_t              state_q, state_d;
    logic                chan_q, chan_d;
    logic                lr_prev_q, lr_prev_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_buf_q, left_buf_d;
    logic                left_vld_q, left_vld_d;
    logic [SAMPLE_W-1:0] right_buf_q, right_buf_d;
    logic                pair_q, pair_d;
    logic                frame_err_q, frame_err_d;
    logic [SAMPLE_W-1:0] word;
    logic                lr_chg;

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        lr_prev_d   = lr_prev_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_buf_d  = left_buf_q;
        left_vld_d  = left_vld_q;
        right_buf_d = right_buf_q;
        pair_d      = 1'b0;
        frame_err_d = 1'b0;
        word        = {shift_q[SAMPLE_W-2:0], data_s};
        lr_chg      = lrclk_s ^ lr_prev_q;
        if (tick) begin
            lr_prev_d = lrclk_s;
            case (state_q)
                StIdle: begin
                    if (lr_prev_q && !lrclk_s) begin
                        state_d = StDelay;
                        chan_d  = ChanL;
                    end
                end
                StDelay, StShift: begin
                    if (lr_chg) begin
                        // Short slot: the partial word and any half-built pair are discarded.
                        frame_err_d = 1'b1;
                        left_vld_d  = 1'b0;
                        state_d     = StDelay;
                        chan_d      = lrclk_s;
                    end else begin
                        shift_d   = word;
                        state_d   = StShift;
                        bit_cnt_d = (state_q == StDelay) ? '0 : bit_cnt_q + 1'b1;
                        if (state_q == StShift && bit_cnt_q == CntW'(SAMPLE_W - 2)) begin
                            state_d = StWait;
                            if (chan_q == ChanL) begin
                                left_buf_d = word;
                                left_vld_d = 1'b1;
                            end else begin
                                right_buf_d = word;
                                pair_d      = left_vld_q;
                                left_vld_d  = 1'b0;
                            end
                        end
                    end
                end
                StWait: begin
                    if (lr_chg) begin
                        state_d = StDelay;
                        chan_d  = lrclk_s;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= StIdle;
            chan_q      <= ChanL;
            lr_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_buf_q  <= '0;
            left_vld_q  <= 1'b0;
            right_buf_q <= '0;
            pair_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            lr_prev_q   <= lr_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_buf_q  <= left_buf_d;
            left_vld_q  <= left_vld_d;
            right_buf_q <= right_buf_d;
            pair_q      <= pair_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Output holding register and handshake.
    logic                out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
    logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        out_valid_d = out_valid_q;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        overrun_d   = 1'b0;
        if (pair_q) begin
            if (!out_valid_q || out_ready) begin
                sample_l_d  = left_buf_q;
                sample_r_d  = right_buf_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid_q <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sample_l  = sample_l_q;
    assign sample_r  = sample_r_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_adio_rx.sv
// Self-checking bench for adio_rx: drives I2S frames at bclk = clk/8 and compares the
// emitted pairs and error pulses against a frame-level reference model.
module tb_adio_rx;

    localparam int SW = 16;
    localparam int SS = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          adc_bclk  = 1'b0;
    logic          adc_lrclk = 1'b0;
    logic          adc_data  = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic          overrun;
    logic          frame_err;
    logic [SW-1:0] sample_l;
    logic [SW-1:0] sample_r;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [2*SW-1:0] obs_q[$];
    logic [2*SW-1:0] exp_q[$];
    int   ovr_cnt      = 0;
    int   ferr_cnt     = 0;
    int   vld_hi_cnt   = 0;
    int   vld_rise_cnt = 0;
    int   vld_rise_cyc = 0;
    int   lsb_rise_cyc = 0;
    logic vld_prev     = 1'b0;
    int   exp_ovr      = 0;
    int   exp_ferr     = 0;
    bit   mdl_held     = 1'b0;

    adio_rx #(
        .SAMPLE_W    (SW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_bclk  (adc_bclk),
        .adc_lrclk (adc_lrclk),
        .adc_data  (adc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sample_l  (sample_l),
        .sample_r  (sample_r),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe just after the falling edge, once stimulus for the next rising edge is settled.
    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) obs_q.push_back({sample_l, sample_r});
        if (overrun) ovr_cnt++;
        if (frame_err) ferr_cnt++;
        if (out_valid) vld_hi_cnt++;
        if (out_valid && !vld_prev) begin
            vld_rise_cnt++;
            vld_rise_cyc = cyc;
        end
        vld_prev = out_valid;
    end

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic bit_cycle(input logic lr, input logic d, output int rise_at);
        @(negedge clk);
        adc_bclk  = 1'b0;
        adc_lrclk = lr;
        adc_data  = d;
        repeat (4) @(negedge clk);
        adc_bclk = 1'b1;
        rise_at  = cyc;
        repeat (3) @(negedge clk);
    endtask

    // Slot bit 0 is the I2S delay bit, bits 1..SW carry the word MSB first, the rest is padding.
    task automatic send_slot(input logic lr, input logic [SW-1:0] w, input int first,
                             input int last);
        int r;
        for (int i = first; i < last; i++) begin
            logic d;
            d = (i >= 1 && i <= SW) ? w[SW-i] : 1'($urandom);
            bit_cycle(lr, d, r);
            if (i == SW) lsb_rise_cyc = r;
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int lbits,
                              input int rbits);
        send_slot(1'b0, l, 0, lbits);
        send_slot(1'b1, r, 0, rbits);
        if (lbits <= SW) begin
            exp_ferr++;
        end else if (mdl_held) begin
            exp_ovr++;
        end else begin
            exp_q.push_back({l, r});
            mdl_held = !out_ready;
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic check_pairs(input string tag);
        check({tag, ".count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, ".pair"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(0));
        check({tag, ".sample_l"}, 64'(sample_l), 64'(0));
        check({tag, ".sample_r"}, 64'(sample_r), 64'(0));
        check({tag, ".overrun"}, 64'(overrun), 64'(0));
        check({tag, ".frame_err"}, 64'(frame_err), 64'(0));
    endtask

    initial begin
        int v0;
        int h0;
        int lb;
        int rb;

        // Reset state
        #1;
        check_zero_outputs("rst");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero_outputs("rst_release");

        // T1: single frame, latency from right LSB to out_valid
        send_slot(1'b1, '0, 0, 4);
        send_frame(16'h1234, 16'hABCD, 32, 32);
        settle();
        check("t1.latency", 64'(vld_rise_cyc - lsb_rise_cyc), 64'(SS + 2));
        check_pairs("t1");
        check("t1.overrun", 64'(ovr_cnt), 64'(exp_ovr));
        check("t1.frame_err", 64'(ferr_cnt), 64'(exp_ferr));

        // T2: downstream stalls across two frames
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(16'h0001, 16'h0002, 32, 32);
        send_frame(16'h0003, 16'h0004, 32, 32);
        settle();
        check("t2.held_valid", 64'(out_valid), 64'(1));
        check("t2.held_l", 64'(sample_l), 64'(16'h0001));
        check("t2.held_r", 64'(sample_r), 64'(16'h0002));
        check("t2.no_take", 64'(obs_q.size()), 64'(0));
        check("t2.overrun", 64'(ovr_cnt), 64'(exp_ovr));
        @(negedge clk);
        out_ready = 1'b1;
        mdl_held  = 1'b0;
        repeat (20) @(negedge clk);
        check("t2.drained", 64'(out_valid), 64'(0));
        check_pairs("t2");

        // T3: short left slots (10 bits, and final bit on the lrclk edge) and minimal legal slots
        send_frame(16'h1111, 16'h2222, 10, 32);
        send_frame(16'h5555, 16'hAAAA, 32, 32);
        send_frame(16'h3333, 16'h4444, SW, 32);
        send_frame(16'h6666, 16'h7777, SW + 1, SW + 1);
        settle();
        check_pairs("t3");
        check("t3.frame_err", 64'(ferr_cnt), 64'(exp_ferr));
        check("t3.overrun", 64'(ovr_cnt), 64'(exp_ovr));

        // T4: reset, then stimulus starts mid right slot
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_slot(1'b1, SW'($urandom), 10, 32);
        send_frame(16'h7FFF, 16'h8000, 32, 32);
        settle();
        check_pairs("t4");
        check("t4.frame_err", 64'(ferr_cnt), 64'(exp_ferr));

        // T5: reset while the left word is being shifted
        send_slot(1'b0, 16'h1357, 0, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("t5.rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_slot(1'b0, 16'h1357, 8, 32);
        send_slot(1'b1, 16'h2468, 0, 32);
        send_frame(16'h0F0F, 16'hF0F0, 32, 32);
        settle();
        check_pairs("t5");
        check("t5.frame_err", 64'(ferr_cnt), 64'(exp_ferr));

        // T6: ready tied high, four back-to-back random frames
        v0 = vld_rise_cnt;
        h0 = vld_hi_cnt;
        for (int f = 0; f < 4; f++) begin
            send_frame(SW'($urandom), SW'($urandom), 32, 32);
        end
        settle();
        check("t6.rises", 64'(vld_rise_cnt - v0), 64'(4));
        check("t6.high_cycles", 64'(vld_hi_cnt - h0), 64'(4));
        check_pairs("t6");

        // T7: random slot lengths, occasionally short left slots
        for (int f = 0; f < 6; f++) begin
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, SW) : $urandom_range(SW + 1, 34);
            rb = $urandom_range(SW + 1, 34);
            send_frame(SW'($urandom), SW'($urandom), lb, rb);
        end
        settle();
        check_pairs("t7");
        check("t7.frame_err", 64'(ferr_cnt), 64'(exp_ferr));
        check("t7.overrun", 64'(ovr_cnt), 64'(exp_ovr));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
